// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: processes DIGIT bits per clock, LSB digit first,
// with the carry kept in a register between digits; result published with a done pulse.
module digit_serial_addsub #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, s_q, s_d;
  logic             c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [DIGIT:0]   dsum;
  logic [WIDTH+DIGIT-1:0] acc_shift;
  logic             msb_cin;
  logic             accept;
  logic             last;

  always_comb begin
    dsum      = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_q};
    // New digit enters at the top; after N digits the register holds the full result.
    acc_shift = {dsum[DIGIT-1:0], acc_q};
    msb_cin   = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1];
    last      = (k_q == K_LAST);
    accept    = start && (state_q != RUN);

    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    acc_d   = acc_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        c_d   = dsum[DIGIT];
        acc_d = acc_shift[WIDTH+DIGIT-1:DIGIT];
        k_d   = k_q + 1'b1;
        if (last) begin
          state_d = DONE;
          s_d     = acc_shift[WIDTH+DIGIT-1:DIGIT];
          cout_d  = dsum[DIGIT];
          ovf_d   = msb_cin ^ dsum[DIGIT];
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          state_d = RUN;
          a_d     = a;
          // Subtraction as a + ~b + ~borrow.
          b_d     = sub ? ~b : b;
          c_d     = cin ^ sub;
          k_d     = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    c_q   <= c_d;
    acc_q <= acc_d;
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench for digit_serial_addsub: three instances (32/8, 16/16, 16/4) share stimulus and
// are compared every cycle against a cycle-count/arithmetic reference, plus literal checks.
module tb_digit_serial_addsub;

  logic        clk = 1'b0;
  logic        rst, start, cin, sub;
  logic [31:0] a, b;

  logic        busy0, done0, cout0, ovf0;
  logic [31:0] s0;
  logic        busy1, done1, cout1, ovf1;
  logic [15:0] s1;
  logic        busy2, done2, cout2, ovf2;
  logic [15:0] s2;

  int n_chk = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  int lat0, lat1, lat2;

  int     WW[3] = '{32, 16, 16};
  int     NN[3] = '{4, 1, 4};
  int     mcnt[3];
  bit     mdone[3], mco[3], mov[3], pco[3], pov[3];
  longint ms[3], ps[3];

  always #5 clk = ~clk;

  digit_serial_addsub #(.WIDTH(32), .DIGIT(8)) u0 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy0), .done(done0), .s(s0), .cout(cout0), .ovf(ovf0));
  digit_serial_addsub #(.WIDTH(16), .DIGIT(16)) u1 (
    .clk(clk), .rst(rst), .start(start), .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
    .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1));
  digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) u2 (
    .clk(clk), .rst(rst), .start(start), .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
    .busy(busy2), .done(done2), .s(s2), .cout(cout2), .ovf(ovf2));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Plain-arithmetic reference: result, carry/no-borrow, and signed range overflow.
  function automatic void calc(input int w, input longint ia, input longint ib,
                               input bit icin, input bit isub,
                               output longint rs, output bit rco, output bit rov);
    longint mask, r, sa, sb, sr, half;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ia = ia & mask;
    ib = ib & mask;
    r  = isub ? ia - ib - icin : ia + ib + icin;
    rs = r & mask;
    rco = isub ? (ia >= ib + icin) : (r > mask);
    sa = (ia >= half) ? ia - (longint'(1) << w) : ia;
    sb = (ib >= half) ? ib - (longint'(1) << w) : ib;
    sr = isub ? sa - sb - icin : sa + sb + icin;
    rov = (sr >= half) || (sr < -half);
  endfunction

  always @(negedge clk) begin
    logic        ab, ad, ac, ao;
    logic [31:0] as;
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        case (i)
          0:       begin ab = busy0; ad = done0; as = s0;          ac = cout0; ao = ovf0; end
          1:       begin ab = busy1; ad = done1; as = {16'h0, s1}; ac = cout1; ao = ovf1; end
          default: begin ab = busy2; ad = done2; as = {16'h0, s2}; ac = cout2; ao = ovf2; end
        endcase
        check($sformatf("busy%0d", i), 64'(ab), 64'(mcnt[i] > 0));
        check($sformatf("done%0d", i), 64'(ad), 64'(mdone[i]));
        check($sformatf("s%0d", i),    64'(as), ms[i]);
        check($sformatf("cout%0d", i), 64'(ac), 64'(mco[i]));
        check($sformatf("ovf%0d", i),  64'(ao), 64'(mov[i]));
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mcnt[i] = 0; mdone[i] = 0; ms[i] = 0; mco[i] = 0; mov[i] = 0;
      end else if (mcnt[i] > 0) begin
        mcnt[i]--;
        mdone[i] = (mcnt[i] == 0);
        if (mdone[i]) begin
          ms[i] = ps[i]; mco[i] = pco[i]; mov[i] = pov[i];
        end
      end else begin
        mdone[i] = 0;
        if (start) begin
          calc(WW[i], longint'(a), longint'(b), cin, sub, ps[i], pco[i], pov[i]);
          mcnt[i] = NN[i];
        end
      end
    end
    mon_en = 1'b1;
  end

  // Called #1 after an edge; start is sampled at the next edge. Optionally pokes a
  // start with other operands, or a reset, at a given cycle after acceptance.
  task automatic go(input logic [31:0] ia, input logic [31:0] ib, input logic icin,
                    input logic isub, input int poke, input int rst_at);
    a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_first_cycle", 64'(busy0), 64'd1);
    lat0 = 0; lat1 = 0; lat2 = 0;
    for (int c = 1; c <= 12; c++) begin
      if (done1 && lat1 == 0) lat1 = c;
      if (done2 && lat2 == 0) lat2 = c;
      if (done0) begin
        lat0 = c;
        check("busy_with_done", 64'(busy0), 64'd0);
        break;
      end
      if (rst_at > 0 && c == rst_at + 1) begin
        check("busy_after_rst", 64'(busy0), 64'd0);
        check("s_after_rst", 64'(s0), 64'd0);
      end
      if (c == poke)       begin start = 1'b1; a = 32'hDEADBEEF; b = 32'h12345; end
      if (c == poke + 1)   begin start = 1'b0; a = 32'h0BADF00D; end
      if (c == rst_at)     rst = 1'b1;
      if (c == rst_at + 1) rst = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_done", 64'(done0), 64'd0);
    check("rst_s",    64'(s0),    64'd0);
    check("rst_cout", 64'(cout0), 64'd0);
    check("rst_ovf",  64'(ovf0),  64'd0);

    go(32'd15, 32'd25, 1'b1, 1'b0, 0, 0);
    check("add_lat0", 64'(lat0), 64'd5);
    check("add_lat1", 64'(lat1), 64'd2);
    check("add_lat2", 64'(lat2), 64'd5);
    check("add_s",    64'(s0),   64'd41);
    check("add_cout", 64'(cout0), 64'd0);
    check("add_ovf",  64'(ovf0),  64'd0);
    repeat (3) begin @(posedge clk); #1; end
    check("add_hold", 64'(s0), 64'd41);

    go(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 0, 0);
    check("wrap_s",     64'(s0),    64'd0);
    check("wrap_cout",  64'(cout0), 64'd1);
    check("wrap_ovf",   64'(ovf0),  64'd0);
    check("wrap16_s",   64'(s1),    64'd0);
    check("wrap16_cout", 64'(cout1), 64'd1);

    go(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 0, 0);
    check("ovf_s",    64'(s0),    64'h80000000);
    check("ovf_cout", 64'(cout0), 64'd0);
    check("ovf_ovf",  64'(ovf0),  64'd1);

    go(32'd100, 32'd200, 1'b0, 1'b1, 0, 0);
    check("sub_s",    64'(s0),    64'hFFFFFF9C);
    check("sub_cout", 64'(cout0), 64'd0);
    check("sub_ovf",  64'(ovf0),  64'd0);
    check("sub16_s",  64'(s2),    64'hFF9C);
    check("sub16_lat", 64'(lat2), 64'd5);

    go(32'd1000000, 32'd1000000, 1'b1, 1'b1, 0, 0);
    check("borrow_s",    64'(s0),    64'hFFFFFFFF);
    check("borrow_cout", 64'(cout0), 64'd0);

    go(32'd1000000, 32'd1000000, 1'b0, 1'b0, 0, 0);
    check("b2b_lat", 64'(lat0), 64'd5);
    check("b2b_s",   64'(s0),   64'd2000000);

    go(32'd5, 32'd6, 1'b0, 1'b0, 2, 0);
    check("ignore_lat", 64'(lat0), 64'd5);
    check("ignore_s",   64'(s0),   64'd11);

    go(32'd7, 32'd8, 1'b0, 1'b0, 0, 2);
    check("rst_no_done", 64'(lat0), 64'd0);

    for (int i = 0; i < 1000; i++)
      go($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
